// File: rtl/bandit_environment.sv
// bandit_environment: stochastic reward source for a multi-armed bandit agent.
// It looks up a per-arm success probability, draws a Bernoulli trial from an LFSR and returns the reward.
`default_nettype none

module bandit_environment #(
  parameter int          ARMS         = 256,
  parameter int          ACTION_WIDTH = 8,
  parameter int          REWARD_WIDTH = 16,
  parameter int          PROB_WIDTH   = 16,
  parameter int          REWARD_VALUE = 255,
  parameter logic [31:0] SEED         = 32'hACE1_2018
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    action_valid,
  input  logic [ACTION_WIDTH-1:0] action_data,
  output logic                    action_ready,
  output logic                    reward_valid,
  output logic [REWARD_WIDTH-1:0] reward_data,
  input  logic                    reward_ready,
  input  logic                    prob_write,
  input  logic [ACTION_WIDTH-1:0] prob_address,
  input  logic [PROB_WIDTH-1:0]   prob_data,
  output logic [31:0]             trial_count
);

  typedef enum logic [1:0] {IDLE, LOOKUP, SAMPLE, RESPOND} state_t;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] LFSR_INIT = (SEED == 32'd0) ? 32'd1 : SEED;

  state_t                    state_q, state_d;
  logic [31:0]               lfsr_q, lfsr_d;
  logic [ACTION_WIDTH-1:0]   arm_q, arm_d;
  logic                      action_ready_q, action_ready_d;
  logic                      reward_valid_q, reward_valid_d;
  logic [REWARD_WIDTH-1:0]   reward_data_q, reward_data_d;
  logic [31:0]               trial_count_q, trial_count_d;
  logic [PROB_WIDTH-1:0]     prob_q;
  logic [PROB_WIDTH-1:0]     table_q [ARMS];
  logic                      arm_in_range;
  logic                      waddr_in_range;
  logic                      success;

  assign arm_in_range   = 32'(arm_q) < ARMS;
  assign waddr_in_range = 32'(prob_address) < ARMS;
  // All-ones is a certain success even when the sample is also all-ones.
  assign success = (prob_q == '1) || (lfsr_q[PROB_WIDTH-1:0] < prob_q);

  always_comb begin
    state_d        = state_q;
    arm_d          = arm_q;
    action_ready_d = action_ready_q;
    reward_valid_d = reward_valid_q;
    reward_data_d  = reward_data_q;
    trial_count_d  = trial_count_q;
    lfsr_d         = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);

    unique case (state_q)
      IDLE: begin
        action_ready_d = 1'b1;
        if (action_valid && action_ready_q) begin
          arm_d          = action_data;
          action_ready_d = 1'b0;
          state_d        = LOOKUP;
        end
      end
      LOOKUP: state_d = SAMPLE;
      SAMPLE: begin
        reward_data_d  = success ? REWARD_WIDTH'(REWARD_VALUE) : '0;
        reward_valid_d = 1'b1;
        state_d        = RESPOND;
      end
      RESPOND: begin
        if (reward_ready) begin
          reward_valid_d = 1'b0;
          reward_data_d  = '0;
          trial_count_d  = trial_count_q + 32'd1;
          action_ready_d = 1'b1;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      lfsr_q         <= LFSR_INIT;
      arm_q          <= '0;
      action_ready_q <= 1'b0;
      reward_valid_q <= 1'b0;
      reward_data_q  <= '0;
      trial_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      lfsr_q         <= lfsr_d;
      arm_q          <= arm_d;
      action_ready_q <= action_ready_d;
      reward_valid_q <= reward_valid_d;
      reward_data_q  <= reward_data_d;
      trial_count_q  <= trial_count_d;
    end
  end

  // Table survives reset; the LOOKUP read sees the pre-write value on a same-edge write.
  always_ff @(posedge clock) begin
    if (prob_write && waddr_in_range) begin
      table_q[prob_address] <= prob_data;
    end
    if (state_q == LOOKUP) begin
      prob_q <= arm_in_range ? table_q[arm_q] : '0;
    end
  end

  assign action_ready = action_ready_q;
  assign reward_valid = reward_valid_q;
  assign reward_data  = reward_data_q;
  assign trial_count  = trial_count_q;

endmodule

`default_nettype wire
